pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register succeeding the fixed ID/EX register. It carries a control field and a data payload from stage D to stage E with a valid/ready handshake and a two-entry skid buffer, so stalls propagate without combinational ready paths. It also provides a synchronous flush that inserts a bubble and a saturating bubble counter. It is instantiated between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-stage widths.

---
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W     = 10,
  parameter int unsigned DATA_W     = 165,
  parameter int unsigned CLEAR_DATA = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ValidD,
  output logic              ReadyD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [DATA_W-1:0] DataD,
  output logic              ValidE,
  input  logic              ReadyE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [DATA_W-1:0] DataE,
  input  logic              FlushE,
  output logic [CNT_W-1:0]  BubbleCnt
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept, take;

  assign accept = ValidD & ready_q;
  assign take   = valid_q & ReadyE;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (FlushE) begin
      state_d     = StEmpty;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_ctrl_d = CtrlD;
            main_data_d = DataD;
            state_d     = StFull;
          end
        end
        StFull: begin
          if (accept && take) begin
            main_ctrl_d = CtrlD;
            main_data_d = DataD;
          end else if (accept) begin
            skid_ctrl_d = CtrlD;
            skid_data_d = DataD;
            state_d     = StSkid;
          end else if (take) begin
            // Bubble must carry no side-effecting control bits.
            main_ctrl_d = '0;
            state_d     = StEmpty;
          end
        end
        StSkid: begin
          if (take) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            state_d     = StFull;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    valid_d = (state_d != StEmpty);
    ready_d = (state_d != StSkid);
    cnt_d   = cnt_q;
    if (!valid_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StEmpty;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ReadyD    = ready_q;
  assign ValidE    = valid_q;
  assign CtrlE     = main_ctrl_q;
  assign DataE     = main_data_q;
  assign BubbleCnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (default and CLEAR_DATA=0/CNT_W=4)
// sharing stimulus, checked against a queue-based reference model.
module tb_pipe_stage_reg;
  localparam int CW = 10;
  localparam int DW = 165;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_d = 1'b0;
  logic          ready_e = 1'b0;
  logic          flush_e = 1'b0;
  logic [CW-1:0] ctrl_d = '0;
  logic [DW-1:0] data_d = '0;

  logic          ready_a, valid_a, ready_b, valid_b;
  logic [CW-1:0] ctrl_a, ctrl_b;
  logic [DW-1:0] data_a, data_b;
  logic [15:0]   cnt_a;
  logic [3:0]    cnt_b;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] m_data_a = '0;
  logic [DW-1:0] m_data_b = '0;
  int unsigned   m_cnt_a = 0;
  int unsigned   m_cnt_b = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut_a (
    .CLK(clk), .RST(rst), .ValidD(valid_d), .ReadyD(ready_a), .CtrlD(ctrl_d), .DataD(data_d),
    .ValidE(valid_a), .ReadyE(ready_e), .CtrlE(ctrl_a), .DataE(data_a), .FlushE(flush_e),
    .BubbleCnt(cnt_a)
  );

  pipe_stage_reg #(.CLEAR_DATA(0), .CNT_W(4)) dut_b (
    .CLK(clk), .RST(rst), .ValidD(valid_d), .ReadyD(ready_b), .CtrlD(ctrl_d), .DataD(data_d),
    .ValidE(valid_b), .ReadyE(ready_e), .CtrlE(ctrl_b), .DataE(data_b), .FlushE(flush_e),
    .BubbleCnt(cnt_b)
  );

  // Model: FIFO of at most two entries; head is what the E side sees.
  task automatic tick();
    bit take, acc;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_data_a = '0;
      m_data_b = '0;
      m_cnt_a  = 0;
      m_cnt_b  = 0;
    end else begin
      if (q.size() == 0) begin
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_b < 15) m_cnt_b++;
      end
      if (flush_e) begin
        q.delete();
        m_data_a = '0;
      end else begin
        take = (q.size() > 0) && ready_e;
        acc  = valid_d && (q.size() < 2);
        if (take) void'(q.pop_front());
        if (acc) q.push_back('{ctrl_d, data_d});
      end
      if (q.size() > 0) begin
        m_data_a = q[0].d;
        m_data_b = q[0].d;
      end
    end
    #1;
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
    valid_d = 1'b1;
    ctrl_d  = c;
    data_d  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    compared += 5;
    if (valid_a !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b want 0", valid_a); end
    if (ctrl_a !== '0) begin mismatched++; $display("FAIL reset_ctrl: got %0h want 0", ctrl_a); end
    if (data_a !== '0) begin mismatched++; $display("FAIL reset_data: got %0h want 0", data_a); end
    if (ready_a !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %0b want 1", ready_a); end
    if (cnt_a !== 16'd5) begin mismatched++; $display("FAIL reset_bubblecnt: got %0d want 5", cnt_a); end
  endtask

  task automatic test_streaming();
    ready_e = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(10'h3FF, DW'(i));
      tick();
      compared += 3;
      if (valid_a !== 1'b1) begin mismatched++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, valid_a); end
      if (ctrl_a !== 10'h3FF) begin mismatched++; $display("FAIL stream_ctrl[%0d]: got %0h want 3ff", i, ctrl_a); end
      if (data_a !== DW'(i)) begin mismatched++; $display("FAIL stream_data[%0d]: got %0h want %0h", i, data_a, i); end
    end
    valid_d = 1'b0;
    tick();
    compared++;
    if (valid_a !== 1'b0) begin mismatched++; $display("FAIL stream_drain: got %0b want 0", valid_a); end
  endtask

  task automatic test_stall_skid();
    logic [DW-1:0] exp_seq[3];
    exp_seq[0] = DW'(32'hA0A);
    exp_seq[1] = DW'(32'hB0B);
    exp_seq[2] = DW'(32'hC0C);
    ready_e = 1'b1;
    push(10'h011, exp_seq[0]);
    tick();
    ready_e = 1'b0;
    push(10'h022, exp_seq[1]);
    tick();
    compared += 2;
    if (ready_a !== 1'b0) begin mismatched++; $display("FAIL skid_ready: got %0b want 0", ready_a); end
    if (data_a !== exp_seq[0]) begin mismatched++; $display("FAIL skid_main: got %0h want %0h", data_a, exp_seq[0]); end
    push(10'h033, exp_seq[2]);
    tick();
    compared += 2;
    if (ready_a !== 1'b0) begin mismatched++; $display("FAIL skid_c_blocked: got %0b want 0", ready_a); end
    if (data_a !== exp_seq[0]) begin mismatched++; $display("FAIL skid_hold: got %0h want %0h", data_a, exp_seq[0]); end
    ready_e = 1'b1;
    // A is taken now; B then C follow on consecutive cycles with C held on the input.
    for (int i = 1; i < 3; i++) begin
      tick();
      compared += 2;
      if (valid_a !== 1'b1) begin mismatched++; $display("FAIL drain_valid[%0d]: got %0b want 1", i, valid_a); end
      if (data_a !== exp_seq[i]) begin mismatched++; $display("FAIL drain_data[%0d]: got %0h want %0h", i, data_a, exp_seq[i]); end
    end
    valid_d = 1'b0;
    tick();
    compared++;
    if (valid_a !== 1'b0) begin mismatched++; $display("FAIL drain_no_dup: got %0b want 0", valid_a); end
  endtask

  task automatic test_flush_mid_stall();
    ready_e = 1'b0;
    push(10'h155, DW'(32'h1111));
    tick();
    push(10'h0AA, DW'(32'h2222));
    tick();
    flush_e = 1'b1;
    push(10'h3FF, DW'(32'hD00D));
    tick();
    flush_e = 1'b0;
    valid_d = 1'b0;
    compared += 5;
    if (valid_a !== 1'b0) begin mismatched++; $display("FAIL flush_valid: got %0b want 0", valid_a); end
    if (ctrl_a !== '0) begin mismatched++; $display("FAIL flush_ctrl: got %0h want 0", ctrl_a); end
    if (data_a !== '0) begin mismatched++; $display("FAIL flush_data: got %0h want 0", data_a); end
    if (ready_a !== 1'b1) begin mismatched++; $display("FAIL flush_ready: got %0b want 1", ready_a); end
    if (data_b !== DW'(32'h1111)) begin mismatched++; $display("FAIL flush_keep_b: got %0h want 1111", data_b); end
    ready_e = 1'b1;
    repeat (3) begin
      tick();
      compared++;
      if (valid_a !== 1'b0) begin mismatched++; $display("FAIL flush_no_reappear: got %0b want 0", valid_a); end
    end
  endtask

  task automatic test_flush_keep_data();
    ready_e = 1'b0;
    push(10'h2C3, DW'(32'hDEAD));
    tick();
    valid_d = 1'b0;
    flush_e = 1'b1;
    tick();
    flush_e = 1'b0;
    compared += 4;
    if (valid_b !== 1'b0) begin mismatched++; $display("FAIL keep_valid: got %0b want 0", valid_b); end
    if (ctrl_b !== '0) begin mismatched++; $display("FAIL keep_ctrl: got %0h want 0", ctrl_b); end
    if (data_b !== DW'(32'hDEAD)) begin mismatched++; $display("FAIL keep_data: got %0h want dead", data_b); end
    if (data_a !== '0) begin mismatched++; $display("FAIL keep_clear_a: got %0h want 0", data_a); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid_d = $urandom_range(0, 3) != 0;
      ready_e = $urandom_range(0, 2) != 0;
      flush_e = $urandom_range(0, 15) == 0;
      ctrl_d  = CW'($urandom);
      data_d  = DW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      tick();
      compared += 10;
      if (valid_a !== (q.size() > 0)) begin mismatched++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, valid_a, q.size() > 0); end
      if (ready_a !== (q.size() < 2)) begin mismatched++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, ready_a, q.size() < 2); end
      if (ctrl_a !== ((q.size() > 0) ? q[0].c : CW'(0))) begin mismatched++; $display("FAIL rnd_ctrl[%0d]: got %0h", i, ctrl_a); end
      if (data_a !== m_data_a) begin mismatched++; $display("FAIL rnd_data[%0d]: got %0h want %0h", i, data_a, m_data_a); end
      if (cnt_a !== 16'(m_cnt_a)) begin mismatched++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, cnt_a, m_cnt_a); end
      if (valid_b !== (q.size() > 0)) begin mismatched++; $display("FAIL rnd_valid_b[%0d]: got %0b", i, valid_b); end
      if (ready_b !== (q.size() < 2)) begin mismatched++; $display("FAIL rnd_ready_b[%0d]: got %0b", i, ready_b); end
      if (ctrl_b !== ((q.size() > 0) ? q[0].c : CW'(0))) begin mismatched++; $display("FAIL rnd_ctrl_b[%0d]: got %0h", i, ctrl_b); end
      if (data_b !== m_data_b) begin mismatched++; $display("FAIL rnd_data_b[%0d]: got %0h want %0h", i, data_b, m_data_b); end
      if (cnt_b !== 4'(m_cnt_b)) begin mismatched++; $display("FAIL rnd_cnt_b[%0d]: got %0d want %0d", i, cnt_b, m_cnt_b); end
    end
    valid_d = 1'b0;
    flush_e = 1'b0;
    ready_e = 1'b1;
  endtask

  task automatic test_saturation();
    valid_d = 1'b0;
    flush_e = 1'b0;
    repeat (20) tick();
    compared++;
    if (cnt_b !== 4'd15) begin mismatched++; $display("FAIL sat_cnt: got %0d want 15", cnt_b); end
    tick();
    compared++;
    if (cnt_b !== 4'd15) begin mismatched++; $display("FAIL sat_hold: got %0d want 15", cnt_b); end
    rst = 1'b1;
    flush_e = 1'b1;
    tick();
    rst = 1'b0;
    flush_e = 1'b0;
    compared += 7;
    if (cnt_a !== 16'd0) begin mismatched++; $display("FAIL rst_cnt_a: got %0d want 0", cnt_a); end
    if (cnt_b !== 4'd0) begin mismatched++; $display("FAIL rst_cnt_b: got %0d want 0", cnt_b); end
    if (valid_b !== 1'b0) begin mismatched++; $display("FAIL rst_valid_b: got %0b want 0", valid_b); end
    if (ctrl_b !== '0) begin mismatched++; $display("FAIL rst_ctrl_b: got %0h want 0", ctrl_b); end
    if (data_b !== '0) begin mismatched++; $display("FAIL rst_data_b: got %0h want 0", data_b); end
    if (data_a !== '0) begin mismatched++; $display("FAIL rst_data_a: got %0h want 0", data_a); end
    if (ready_b !== 1'b1) begin mismatched++; $display("FAIL rst_ready_b: got %0b want 1", ready_b); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush_mid_stall();
    test_flush_keep_data();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
